// File: rtl/ramb4_rd_pkg.sv
// Shared definitions for the 4096x1 block-RAM stream reader.
package ramb4_rd_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/ramb4_bit_packer.sv
// Packs a serial bit stream into WORD_W-bit words held in one output register
// with valid/ready; stall tells the reader that a bit issued now has no home.
module ramb4_bit_packer #(
  parameter int WORD_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_last,
  output logic              stall,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int FW = $clog2(WORD_W + 1);
  localparam logic [FW-1:0] FULL_L = FW'(WORD_W);
  localparam logic [FW-1:0] FONE_L = FW'(1);
  localparam logic [FW-1:0] FZERO_L = FW'(0);

  logic [WORD_W-1:0] acc_r, acc_s;
  logic [FW-1:0]     fill_r, fill_s, fill_n_s;
  logic              last_r, last_s;
  logic              flush_s, move_s, out_free_s;
  logic [WORD_W-1:0] data_r;
  logic              valid_r, mlast_r;

  // Merge the arriving bit, then decide whether the accumulator moves out.
  always_comb begin
    acc_s      = acc_r;
    fill_s     = in_valid ? (fill_r + FONE_L) : fill_r;
    last_s     = in_valid ? in_last : last_r;
    for (int k = 0; k < WORD_W; k++) begin
      acc_s[LSB_FIRST ? k : WORD_W-1-k] = (in_valid && (fill_r == FW'(k))) ?
        in_bit : acc_r[LSB_FIRST ? k : WORD_W-1-k];
    end
    out_free_s = !valid_r || m_ready;
    flush_s    = (fill_s == FULL_L) || last_s;
    move_s     = flush_s && out_free_s;
    fill_n_s   = move_s ? FZERO_L : fill_s;
    // A full word parked in the accumulator leaves no room for the next bit.
    stall      = (fill_n_s == FULL_L);
  end

  // Accumulator and output holding register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r   <= {WORD_W{1'b0}};
      fill_r  <= FZERO_L;
      last_r  <= 1'b0;
      data_r  <= {WORD_W{1'b0}};
      valid_r <= 1'b0;
      mlast_r <= 1'b0;
    end else begin
      acc_r  <= move_s ? {WORD_W{1'b0}} : acc_s;
      fill_r <= fill_n_s;
      last_r <= move_s ? 1'b0 : last_s;
      if (move_s) begin
        data_r  <= acc_s;
        valid_r <= 1'b1;
        mlast_r <= last_s;
      end else if (valid_r && m_ready) begin
        valid_r <= 1'b0;
        mlast_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
        mlast_r <= mlast_r;
      end
    end
  end

  assign m_data  = data_r;
  assign m_valid = valid_r;
  assign m_last  = mlast_r;

endmodule

// File: rtl/ramb4_s1_stream_reader.sv
// Reads LEN consecutive bits from a 4096x1 RAM starting at BASE and streams
// them out as packed words with full valid/ready backpressure.
module ramb4_s1_stream_reader
  import ramb4_rd_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WORD_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  input  logic              RAM_DO,
  output logic [WORD_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST
);

  localparam logic [ADDR_W:0]   DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_L    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ZERO_L   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  rd_state_e         state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   rem_r;
  logic              inflight_r, inflight_last_r;
  logic              busy_r, done_r;
  logic              stall_s, issue_s, last_acc_s;

  assign issue_s    = (state_r == READ) && !stall_s;
  assign last_acc_s = M_VALID && M_READY && M_LAST;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (START) state_s = (LEN == ZERO_L) ? FIN : READ;
        else       state_s = IDLE;
      end
      READ: begin
        if (issue_s && (rem_r == ONE_L)) state_s = DRAIN;
        else                             state_s = READ;
      end
      DRAIN: begin
        if (last_acc_s) state_s = FIN;
        else            state_s = DRAIN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, address/remaining counters and the read-in-flight tracker.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r         <= IDLE;
      addr_r          <= {ADDR_W{1'b0}};
      rem_r           <= ZERO_L;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      busy_r          <= (state_s != IDLE);
      done_r          <= (state_r == FIN);
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (rem_r == ONE_L);
      if ((state_r == IDLE) && START) begin
        addr_r <= BASE;
        rem_r  <= (LEN > DEPTH_L) ? DEPTH_L : LEN;
      end else if (issue_s) begin
        addr_r <= addr_r + ADDR_ONE;
        rem_r  <= rem_r - ONE_L;
      end else begin
        addr_r <= addr_r;
        rem_r  <= rem_r;
      end
    end
  end

  ramb4_bit_packer #(
    .WORD_W   (WORD_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_packer (
    .CLK     (CLK),
    .RST     (RST),
    .in_valid(inflight_r),
    .in_bit  (RAM_DO),
    .in_last (inflight_last_r),
    .stall   (stall_s),
    .m_data  (M_DATA),
    .m_valid (M_VALID),
    .m_last  (M_LAST),
    .m_ready (M_READY)
  );

  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign RAM_ADDR = addr_r;
  assign RAM_EN   = issue_s;
  assign RAM_WE   = 1'b0;
  assign RAM_RST  = 1'b0;

endmodule

// File: tb/tb_ramb4_s1_stream_reader.sv
// Directed bench for the stream reader against a 4096x1 RAM holding mem[i] = i[0].
module tb_ramb4_s1_stream_reader;

  localparam int AW = 12;
  localparam int WW = 8;

  logic          CLK = 1'b0;
  logic          RST, START, M_READY;
  logic [AW-1:0] BASE, RAM_ADDR;
  logic [AW:0]   LEN;
  logic          BUSY, DONE, RAM_EN, RAM_WE, RAM_RST;
  logic          RAM_DO = 1'b0;
  logic [WW-1:0] M_DATA;
  logic          M_VALID, M_LAST;

  ramb4_s1_stream_reader #(.ADDR_W(AW), .WORD_W(WW), .LSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .RAM_ADDR(RAM_ADDR), .RAM_EN(RAM_EN),
    .RAM_WE(RAM_WE), .RAM_RST(RAM_RST), .RAM_DO(RAM_DO),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST)
  );

  always #5 CLK = ~CLK;

  bit mem [0:4095];
  always @(posedge CLK) if (RAM_EN) RAM_DO <= mem[RAM_ADDR];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            poke;      // relative cycle of a spurious START, 0 = none
    int            nwords;
    logic [WW-1:0] word;      // every word except the final one
    logic [WW-1:0] last_word;
    int            fv;        // first M_VALID cycle, -1 = never
    int            done;      // DONE cycle relative to START
  } vec_t;

  vec_t vecs[9];
  int checks = 0;
  int errors = 0;

  int            cyc = 0;
  int            t0;
  bit            armed = 1'b0;
  logic [AW-1:0] job_base;
  logic [WW-1:0] got_q[$];
  int            last_cnt, last_pos, fv, done_rel, done_cnt, en_cnt, addr_errs, stab_errs;
  bit            prev_stall;
  logic [WW-1:0] prev_data;
  logic          prev_last;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observer: samples on the falling edge, away from DUT updates.
  always @(negedge CLK) begin
    if (armed) begin
      if (prev_stall && (!M_VALID || M_DATA != prev_data || M_LAST != prev_last)) stab_errs++;
      prev_stall = M_VALID && !M_READY;
      prev_data  = M_DATA;
      prev_last  = M_LAST;
      if (RAM_EN) begin
        if (RAM_ADDR != AW'(job_base + en_cnt)) addr_errs++;
        en_cnt++;
      end
      if (M_VALID && fv < 0) fv = cyc - t0;
      if (M_VALID && M_READY) begin
        if (M_LAST) begin
          last_cnt++;
          last_pos = got_q.size();
        end
        got_q.push_back(M_DATA);
      end
      if (DONE) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic arm(input logic [AW-1:0] b);
    got_q.delete();
    last_cnt = 0; last_pos = -1; fv = -1; done_rel = -1; done_cnt = 0;
    en_cnt = 0; addr_errs = 0; stab_errs = 0; prev_stall = 1'b0;
    job_base = b;
    armed = 1'b1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge CLK); #1;
    arm(b);
    BASE = b; LEN = l; START = 1'b1; t0 = cyc;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int poke);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      @(posedge CLK); #1;
      if (poke != 0 && (cyc - t0) == poke) begin
        START = 1'b1; BASE = 12'd7; LEN = 13'd3;
      end else begin
        START = 1'b0;
      end
      n++;
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int bad, exp_en;
    launch(v.base, v.len);
    wait_done(v.poke);
    armed = 1'b0;
    bad = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] != ((i == v.nwords - 1) ? v.last_word : v.word)) bad++;
    exp_en = (v.len > 13'd4096) ? 4096 : int'(v.len);
    chk({tag, " nwords"}, got_q.size(), v.nwords);
    chk({tag, " bad_words"}, bad, 0);
    chk({tag, " last_cnt"}, last_cnt, (v.nwords > 0) ? 1 : 0);
    chk({tag, " last_pos"}, last_pos, v.nwords - 1);
    chk({tag, " first_valid"}, fv, v.fv);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " done_cycle"}, done_rel, v.done);
    chk({tag, " ram_en_cnt"}, en_cnt, exp_en);
    chk({tag, " addr_errs"}, addr_errs, 0);
  endtask

  initial begin
    int n, en_stall;
    for (int i = 0; i < 4096; i++) mem[i] = i[0];
    vecs[0] = '{12'd0,    13'd16,   0, 2,   8'hAA, 8'hAA, 10, 20};
    vecs[1] = '{12'd0,    13'd8,    0, 1,   8'hAA, 8'hAA, 10, 12};
    vecs[2] = '{12'd4092, 13'd8,    0, 1,   8'hAA, 8'hAA, 10, 12};
    vecs[3] = '{12'd1,    13'd5,    0, 1,   8'h00, 8'h15, 7,  9};
    vecs[4] = '{12'd1,    13'd16,   0, 2,   8'h55, 8'h55, 10, 20};
    vecs[5] = '{12'd0,    13'd0,    0, 0,   8'h00, 8'h00, -1, 2};
    vecs[6] = '{12'd3,    13'd9,    0, 2,   8'h55, 8'h01, 10, 13};
    vecs[7] = '{12'd0,    13'd5000, 0, 512, 8'hAA, 8'hAA, 10, 4100};
    vecs[8] = '{12'd0,    13'd16,   5, 2,   8'hAA, 8'hAA, 10, 20};

    RST = 1'b1; START = 1'b0; M_READY = 1'b1; BASE = '0; LEN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst BUSY", BUSY, 0);
    chk("rst DONE", DONE, 0);
    chk("rst RAM_EN", RAM_EN, 0);
    chk("rst M_VALID", M_VALID, 0);
    chk("rst M_LAST", M_LAST, 0);
    chk("rst RAM_ADDR", RAM_ADDR, 0);
    chk("rst M_DATA", M_DATA, 0);
    chk("rst RAM_WE", RAM_WE, 0);
    chk("rst RAM_RST", RAM_RST, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int v = 0; v < 9; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Backpressure: consumer stalls 20 cycles after the second word.
    launch(12'd0, 13'd64);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin @(posedge CLK); #1; n++; end
    M_READY = 1'b0;
    en_stall = 0;
    for (int s = 0; s < 20; s++) begin
      @(negedge CLK);
      if (s >= 15 && RAM_EN) en_stall++;
      @(posedge CLK); #1;
    end
    M_READY = 1'b1;
    @(negedge CLK);
    chk("bp resume_en", RAM_EN, 1);
    wait_done(0);
    armed = 1'b0;
    n = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] != 8'hAA) n++;
    chk("bp nwords", got_q.size(), 8);
    chk("bp bad_words", n, 0);
    chk("bp stable_errs", stab_errs, 0);
    chk("bp en_while_stalled", en_stall, 0);
    chk("bp done_cnt", done_cnt, 1);
    chk("bp last_cnt", last_cnt, 1);
    chk("bp ram_en_cnt", en_cnt, 64);
    chk("bp addr_errs", addr_errs, 0);

    // Reset in the middle of a job, then a clean job afterwards.
    launch(12'd0, 13'd64);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin @(posedge CLK); #1; n++; end
    chk("mid words_before_rst", got_q.size(), 3);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("mid BUSY", BUSY, 0);
    chk("mid M_VALID", M_VALID, 0);
    chk("mid RAM_EN", RAM_EN, 0);
    repeat (8) @(posedge CLK);
    #1;
    armed = 1'b0;
    chk("mid done_cnt", done_cnt, 0);
    run_vec(vecs[3], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
